// File: rtl/calc_pkg.sv
// Shared types for the calculator command scheduler: op encoding, FSM states
// and the default-width command record.
package calc_pkg;

    localparam int CALC_OPW  = 3;
    localparam int CALC_RPTW = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_SHL = 2'b11
    } calc_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } sched_state_e;

    // Field order matches the packing used for FIFO entries: {op, operand, repeat}.
    typedef struct packed {
        calc_op_e               op;
        logic [CALC_OPW-1:0]    operand;
        logic [CALC_RPTW-1:0]   rpt;
    } calc_cmd_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Small synchronous command FIFO with wrap-bit pointers, synchronous flush
// and asynchronous active-low reset.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush, doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/calc_op_scheduler.sv
// Issues buffered {op, operand, repeat} commands to the accumulator datapath,
// one op per clock. Define CALC_SCHED_STATS_EN to add the issue_count output.
module calc_op_scheduler
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = 3,
    parameter int RPTW  = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [OPW-1:0]  cmd_operand,
    input  logic [RPTW-1:0] cmd_repeat,
    input  logic            sched_hold,
    input  logic            sched_flush,
    output logic            alu_en,
    output logic [1:0]      alu_op,
    output logic [OPW-1:0]  alu_operand,
    output logic            cmd_done,
    output logic            busy
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [7:0]      issue_count
`endif
);

    localparam int CW = 2 + OPW + RPTW;

    sched_state_e    state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [OPW-1:0]  operand_q, operand_d;
    logic [RPTW-1:0] remaining_q, remaining_d;
    logic            done_q, done_d;

    logic            fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic [CW-1:0]   fifoHead;

    // Commands always pass through the FIFO; a flush cycle drops the offered command.
    assign fifoPush = cmd_valid && !fifoFull && !sched_flush;

    calc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (sched_flush),
        .push_i  (fifoPush),
        .wdata_i ({cmd_op, cmd_operand, cmd_repeat}),
        .pop_i   (fifoPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign cmd_ready   = !fifoFull;
    assign alu_en      = (state_q == ISSUE) && !sched_hold;
    assign alu_op      = op_q;
    assign alu_operand = operand_q;
    assign cmd_done    = done_q;
    assign busy        = (state_q != IDLE) || !fifoEmpty;

    // Popping on the final repeat of a command keeps issue back-to-back.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_d   = operand_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        fifoPop     = 1'b0;
        if (sched_flush) begin
            state_d = IDLE;
        end else if (!sched_hold) begin
            unique case (state_q)
                IDLE: begin
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        {op_d, operand_d, remaining_d} = fifoHead;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (!fifoEmpty) begin
                            fifoPop = 1'b1;
                            {op_d, operand_d, remaining_d} = fifoHead;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            operand_q   <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

`ifdef CALC_SCHED_STATS_EN
    logic [7:0] issueCount_q;

    // Survives flush on purpose; only reset clears the running total.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issueCount_q <= 8'd0;
        end else if (alu_en) begin
            issueCount_q <= issueCount_q + 8'd1;
        end
    end

    assign issue_count = issueCount_q;
`endif

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Self-checking bench for calc_op_scheduler: directed scenarios plus a
// randomized run against an expanded issue-stream reference model.
module tb_calc_op_scheduler;
    import calc_pkg::*;

    localparam int DEPTH = 4;
    localparam int OPW   = 3;
    localparam int RPTW  = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [OPW-1:0]  cmd_operand;
    logic [RPTW-1:0] cmd_repeat;
    logic            sched_hold;
    logic            sched_flush;
    logic            alu_en;
    logic [1:0]      alu_op;
    logic [OPW-1:0]  alu_operand;
    logic            cmd_done;
    logic            busy;
`ifdef CALC_SCHED_STATS_EN
    logic [7:0]      issue_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [4:0] expIssue[$];
    logic [4:0] gotIssue[$];
    int         doneSeen;

    calc_op_scheduler #(
        .DEPTH (DEPTH),
        .OPW   (OPW),
        .RPTW  (RPTW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_repeat  (cmd_repeat),
        .sched_hold  (sched_hold),
        .sched_flush (sched_flush),
        .alu_en      (alu_en),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .cmd_done    (cmd_done),
        .busy        (busy)
`ifdef CALC_SCHED_STATS_EN
        ,
        .issue_count (issue_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_operand = '0;
        cmd_repeat  = '0;
        sched_hold  = 1'b0;
        sched_flush = 1'b0;
    endtask

    task automatic offer(input logic [1:0] op, input logic [2:0] opd, input logic [2:0] rpt);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opd;
        cmd_repeat  = rpt;
    endtask

    // Reference model: a command is simply rpt+1 copies of {op, operand}, issued in push order.
    task automatic expectCmd(input logic [1:0] op, input logic [2:0] opd, input logic [2:0] rpt);
        for (int i = 0; i <= int'(rpt); i++) expIssue.push_back({op, opd});
    endtask

    task automatic clearModel();
        expIssue.delete();
        gotIssue.delete();
        doneSeen = 0;
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        #1;
        while ((busy || cmd_done) && n < budget) begin
            if (alu_en) gotIssue.push_back({alu_op, alu_operand});
            if (cmd_done) doneSeen++;
            tick();
            n++;
        end
        total++;
        if (busy || cmd_done) begin
            bad++;
            $display("[TB] FAIL drain_timeout: busy=%0b done=%0b after %0d cycles, want idle", busy, cmd_done, n);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({alu_en, alu_op, alu_operand, cmd_done} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got en=%0b op=%0d opd=%0d done=%0b, want all 0", alu_en, alu_op, alu_operand, cmd_done);
        end
        total++;
        if ({busy, cmd_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL reset_status: got busy=%0b ready=%0b, want busy=0 ready=1", busy, cmd_ready);
        end
    endtask

    task automatic test_single();
        offer(OP_ADD, 3'd3, 3'd0);
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({alu_en, busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single_latency: got en=%0b busy=%0b, want en=0 busy=1", alu_en, busy);
        end
        tick();
        total++;
        if ({alu_en, alu_op, alu_operand} !== {1'b1, 2'b00, 3'd3}) begin
            bad++;
            $display("[TB] FAIL single_issue: got en=%0b op=%0d opd=%0d, want en=1 op=0 opd=3", alu_en, alu_op, alu_operand);
        end
        tick();
        total++;
        if ({alu_en, cmd_done, busy} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL single_done: got en=%0b done=%0b busy=%0b, want en=0 done=1 busy=0", alu_en, cmd_done, busy);
        end
        tick();
        total++;
        if (cmd_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_done_pulse: got done=%0b, want 0", cmd_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] want;
        clearModel();
        offer(OP_SUB, 3'd1, 3'd2);
        expectCmd(OP_SUB, 3'd1, 3'd2);
        tick();
        offer(OP_XOR, 3'd5, 3'd1);
        expectCmd(OP_XOR, 3'd5, 3'd1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            want = expIssue.pop_front();
            total++;
            if ({alu_en, alu_op, alu_operand} !== {1'b1, want}) begin
                bad++;
                $display("[TB] FAIL b2b_issue%0d: got en=%0b op=%0d opd=%0d, want en=1 op=%0d opd=%0d",
                         k, alu_en, alu_op, alu_operand, want[4:3], want[2:0]);
            end
            if (cmd_done) doneSeen++;
            tick();
        end
        total++;
        if (alu_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_stop: got en=%0b, want 0", alu_en);
        end
        for (int k = 0; k < 3; k++) begin
            if (cmd_done) doneSeen++;
            tick();
        end
        total++;
        if (doneSeen !== 2) begin
            bad++;
            $display("[TB] FAIL b2b_done_count: got %0d, want 2", doneSeen);
        end
    endtask

    task automatic test_fill_hold();
        logic [1:0] ops  [4] = '{OP_SHL, OP_ADD, OP_XOR, OP_SUB};
        logic [2:0] opds [4] = '{3'd7, 3'd2, 3'd4, 3'd6};
        logic [2:0] rpts [4] = '{3'd0, 3'd1, 3'd0, 3'd2};
        clearModel();
        sched_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(ops[i], opds[i], rpts[i]);
            expectCmd(ops[i], opds[i], rpts[i]);
            total++;
            if (cmd_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL fill_ready%0d: got %0b, want 1", i, cmd_ready);
            end
            tick();
        end
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fill_full: got ready=%0b, want 0", cmd_ready);
        end
        offer(OP_ADD, 3'd1, 3'd7);
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({cmd_ready, alu_en} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL fill_hold_frozen: got ready=%0b en=%0b, want 0 0", cmd_ready, alu_en);
        end
        sched_hold = 1'b0;
        drain(100);
        total++;
        if (gotIssue.size() !== expIssue.size()) begin
            bad++;
            $display("[TB] FAIL fill_issue_count: got %0d, want %0d", gotIssue.size(), expIssue.size());
        end
        for (int k = 0; k < expIssue.size() && k < gotIssue.size(); k++) begin
            total++;
            if (gotIssue[k] !== expIssue[k]) begin
                bad++;
                $display("[TB] FAIL fill_order%0d: got %h, want %h", k, gotIssue[k], expIssue[k]);
            end
        end
        total++;
        if (doneSeen !== 4) begin
            bad++;
            $display("[TB] FAIL fill_done_count: got %0d, want 4", doneSeen);
        end
    endtask

    task automatic test_hold_mid();
        int  enCount;
        int  dnCount;
        bit  holdLeak;
        enCount  = 0;
        dnCount  = 0;
        holdLeak = 1'b0;
        offer(OP_SHL, 3'd2, 3'd3);
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            sched_hold = (cyc >= 2 && cyc <= 4);
            #1;
            if (sched_hold && alu_en !== 1'b0) holdLeak = 1'b1;
            if (alu_en) begin
                enCount++;
                if ({alu_op, alu_operand} !== {2'b11, 3'd2}) holdLeak = 1'b1;
            end
            if (cmd_done) dnCount++;
            tick();
        end
        sched_hold = 1'b0;
        total++;
        if (holdLeak) begin
            bad++;
            $display("[TB] FAIL hold_gate: got issue during hold or wrong op, want none");
        end
        total++;
        if (enCount !== 4) begin
            bad++;
            $display("[TB] FAIL hold_total: got %0d issues, want 4", enCount);
        end
        total++;
        if (dnCount !== 1) begin
            bad++;
            $display("[TB] FAIL hold_done: got %0d pulses, want 1", dnCount);
        end
    endtask

    task automatic test_flush();
        bit leak;
        leak = 1'b0;
        offer(OP_ADD, 3'd1, 3'd3);
        tick();
        offer(OP_SUB, 3'd2, 3'd3);
        tick();
        offer(OP_XOR, 3'd3, 3'd3);
        tick();
        offer(OP_SHL, 3'd4, 3'd0);
        sched_flush = 1'b1;
        tick();
        idleInputs();
        total++;
        if ({alu_en, busy, cmd_done} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL flush_now: got en=%0b busy=%0b done=%0b, want 0 0 0", alu_en, busy, cmd_done);
        end
        for (int k = 0; k < 4; k++) begin
            if (alu_en || cmd_done || busy) leak = 1'b1;
            tick();
        end
        total++;
        if (leak) begin
            bad++;
            $display("[TB] FAIL flush_after: got activity after flush, want none");
        end
    endtask

    task automatic test_reset_mid();
        bit leak;
        leak = 1'b0;
        offer(OP_XOR, 3'd6, 3'd5);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if ({alu_en, alu_op, alu_operand, cmd_done, busy, cmd_ready} !== 9'b0_00_000_0_0_1) begin
            bad++;
            $display("[TB] FAIL reset_mid: got en=%0b op=%0d opd=%0d done=%0b busy=%0b ready=%0b, want 0 0 0 0 0 1",
                     alu_en, alu_op, alu_operand, cmd_done, busy, cmd_ready);
        end
        #1 reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (alu_en || cmd_done || busy) leak = 1'b1;
        end
        total++;
        if (leak) begin
            bad++;
            $display("[TB] FAIL reset_mid_after: got activity after reset, want none");
        end
    endtask

    task automatic test_random();
        int nCmds;
        clearModel();
        nCmds = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_op      = 2'($urandom_range(0, 3));
            cmd_operand = 3'($urandom_range(0, 7));
            cmd_repeat  = 3'($urandom_range(0, 7));
            sched_hold  = ($urandom_range(0, 4) == 0);
            #1;
            if (cmd_valid && cmd_ready) begin
                expectCmd(cmd_op, cmd_operand, cmd_repeat);
                nCmds++;
            end
            if (alu_en) gotIssue.push_back({alu_op, alu_operand});
            if (cmd_done) doneSeen++;
            tick();
        end
        idleInputs();
        drain(2000);
        total++;
        if (gotIssue.size() !== expIssue.size()) begin
            bad++;
            $display("[TB] FAIL rand_issue_count: got %0d, want %0d", gotIssue.size(), expIssue.size());
        end
        for (int k = 0; k < expIssue.size() && k < gotIssue.size(); k++) begin
            total++;
            if (gotIssue[k] !== expIssue[k]) begin
                bad++;
                $display("[TB] FAIL rand_order%0d: got %h, want %h", k, gotIssue[k], expIssue[k]);
            end
        end
        total++;
        if (doneSeen !== nCmds) begin
            bad++;
            $display("[TB] FAIL rand_done_count: got %0d, want %0d", doneSeen, nCmds);
        end
    endtask

`ifdef CALC_SCHED_STATS_EN
    task automatic test_stats();
        int waited;
        doReset();
        total++;
        if (issue_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL stats_reset: got %0d, want 0", issue_count);
        end
        offer(OP_ADD, 3'd1, 3'd5);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        sched_hold  = 1'b1;
        sched_flush = 1'b1;
        tick();
        idleInputs();
        repeat (2) tick();
        total++;
        if (issue_count !== 8'd2) begin
            bad++;
            $display("[TB] FAIL stats_flush: got %0d, want 2", issue_count);
        end
        for (int i = 0; i < 32; i++) begin
            offer(OP_SHL, 3'(i), 3'd7);
            waited = 0;
            while (!cmd_ready && waited < 100) begin
                tick();
                waited++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        clearModel();
        drain(2000);
        total++;
        if (issue_count !== 8'd2) begin
            bad++;
            $display("[TB] FAIL stats_wrap: got %0d, want 2", issue_count);
        end
    endtask
`endif

    initial begin
        idleInputs();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        $display("[TB] starting");
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_hold();
        test_hold_mid();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef CALC_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_op_scheduler.md
Name: calc_op_scheduler

Overview:
Command scheduler in front of the calculator accumulator datapath. It buffers {op, operand, repeat} commands from a requester in a small FIFO. It drives the datapath enable/op/operand lines one operation per clock, repeating each command the requested number of times. It provides back-to-back issue with no idle bubbles, plus hold, flush and completion signalling.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
OPW, 3, operand width in bits
RPTW, 3, repeat field width; issues per command = cmd_repeat+1

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_op  in  2  00 add, 01 sub, 10 xor, 11 shift-left
cmd_operand  in  OPW  operand
cmd_repeat  in  RPTW  extra repetitions
sched_hold  in  1  freeze issue while high
sched_flush  in  1  synchronous abort/empty
alu_en  out  1  datapath enable, one op per cycle
alu_op  out  2  op to datapath
alu_operand  out  OPW  operand to datapath
cmd_done  out  1  one-cycle pulse after last issue of a command
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (reset low, async): FIFO empty; state IDLE; current regs 0; alu_en=0; alu_op=0; alu_operand=0; cmd_done=0; busy=0; cmd_ready=1.
- Push: on a clock edge with cmd_valid && cmd_ready. No bypass: a command always passes through the FIFO.
- When full, cmd_ready=0 and cmd_valid is ignored. A push and a pop on the same edge leave the count unchanged.
- FSM states: IDLE, ISSUE.
- IDLE: if FIFO non-empty and !sched_hold, pop into the current regs (op, operand, remaining=repeat), then go to ISSUE.
- ISSUE: alu_en=1 unless sched_hold. alu_op and alu_operand come from the current regs and are stable the whole cycle.
- On each edge in ISSUE with !sched_hold:
  - remaining>0: decrement remaining.
  - remaining==0: cmd_done<=1 for the next cycle. If the FIFO is non-empty, pop the next command and stay in ISSUE (back-to-back). Otherwise go to IDLE.
- sched_hold in ISSUE: alu_en=0; remaining and the FIFO are frozen; pushes are still accepted.
- Latency: a push accepted at edge N into an empty FIFO with the FSM IDLE gives alu_en high in the cycle after edge N+1.
- A command with repeat=R produces exactly R+1 consecutive alu_en cycles (absent hold).
- sched_flush has priority over push, pop and issue: FIFO emptied; state IDLE; alu_en=0 from the next cycle; no cmd_done for the aborted command. cmd_valid in a flush cycle is dropped.
- remaining counter is RPTW bits with no wrap. The maximum repeat (2^RPTW-1) issues 2^RPTW times.
- FIFO pointers are log2(DEPTH) bits plus a wrap bit for the full/empty distinction. Pointers wrap modulo DEPTH.
- busy=1 from the edge after a push until the edge after the last issue, when the FIFO is empty.

Optional Feature:
CALC_SCHED_STATS_EN
- Defined: adds output issue_count [7:0], incremented on every edge where alu_en=1. It wraps 255->0, is cleared by reset, and is not cleared by flush.
- Undefined: no port and no counter logic.

Decomposition:
- Package calc_pkg: op encoding enum (OP_ADD, OP_SUB, OP_XOR, OP_SHL), state typedef (IDLE, ISSUE), command struct {op, operand, repeat}.
- One sub-module: calc_cmd_fifo. Parameterised DEPTH/width; push/pop/full/empty/flush; async active-low reset.

Test Plan:
- Reset mid-ISSUE (repeat=5, after 2 issues): all outputs 0, cmd_ready=1 immediately, no cmd_done.
- Push {add, 3, repeat 0} into an empty FIFO at edge 0: alu_en high exactly one cycle (after edge 1) with op=00, operand=3; cmd_done pulses the following cycle; busy then 0.
- Push {sub,1,r2} and {xor,5,r1} back-to-back: 5 consecutive alu_en cycles (sub x3, xor x2), no gap; cmd_done pulses twice.
- Fill DEPTH=4 while sched_hold=1: cmd_ready=0 after the 4th push and a 5th valid is ignored. Release hold: 4 commands issue in order.
- Hold for 3 cycles during {shl,2,r3}: alu_en=0 for those cycles; total alu_en cycles still 4.
- Flush with 2 queued and 1 active: alu_en=0 next cycle, busy=0, no cmd_done. With CALC_SCHED_STATS_EN, issue_count is unchanged by the flush and wraps after 256 issues.
